isp_frame_sequencer: RTL and testbench

Wishbone-configured frame timing controller that sequences the ISP pixel datapath. It generates per-pixel valid strobes and pixel coordinates for a programmable WIDTH x HEIGHT frame, with horizontal blanking between lines. Frame and line markers are emitted alongside, and downstream backpressure is honoured. It sits between the management-SoC Wishbone bus and the ISP io/datapath stage, and raises a frame-done interrupt.

---
 rtl/isp_pkg.sv | 28 ++
 rtl/isp_seq_regs.sv | 132 +++++++++++++
 rtl/isp_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_isp_frame_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP frame sequencer.
// Holds the register map indices, CTRL/STATUS bit positions and the
// sequencer FSM state encoding used by the top level and the register bank.
package isp_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_WIDTH  = 3'd1;
  localparam logic [2:0] REG_HEIGHT = 3'd2;
  localparam logic [2:0] REG_HBLANK = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CONT_BIT   = 1;
  localparam int CTRL_START_BIT  = 2;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_ERR_BIT   = 1;
  localparam int STAT_ABORT_BIT = 2;
  localparam int STAT_FCNT_LSB  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/isp_seq_regs.sv
// Wishbone slave and register bank for the ISP frame sequencer.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   wbs_*                 : Wishbone slave (single-cycle ack, registered read data)
//   busy, frame_cnt       : live status from the sequencer
//   set_err, set_abort    : one-cycle requests to set the sticky flags
//   enable, continuous    : CTRL bits
//   start                 : one-cycle pulse after a CTRL write with bit 2 set
//   width, height, hblank : programmed frame geometry (latched by the FSM at frame start)
module isp_seq_regs
  import isp_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              busy,
  input  logic [FCNT_W-1:0] frame_cnt,
  input  logic              set_err,
  input  logic              set_abort,
  output logic              enable,
  output logic              continuous,
  output logic              start,
  output logic [BITS-1:0]   width,
  output logic [BITS-1:0]   height,
  output logic [BITS-1:0]   hblank
);

  logic            wb_fire;
  logic            wr_fire;
  logic [2:0]      reg_idx;
  logic [31:0]     lane_mask;
  logic [BITS-1:0] byte_mask;
  logic [BITS-1:0] wr_data;
  logic [BITS-1:0] rd_data;
  logic [31:0]     rd32;
  logic            err_sticky;
  logic            abort_sticky;
  logic            ctrl_wr;
  logic            status_wr;
  logic            unused_bits;

  // A transaction is accepted only while ack is low, so each strobe gets
  // exactly one ack pulse even if the master holds cyc/stb for an extra cycle.
  assign wb_fire   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_fire   = wb_fire & wbs_we_i;
  assign reg_idx   = wbs_adr_i[4:2];
  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign byte_mask = lane_mask[BITS-1:0];
  assign wr_data   = wbs_dat_i[BITS-1:0];
  assign ctrl_wr   = wr_fire && (reg_idx == REG_CTRL);
  assign status_wr = wr_fire && (reg_idx == REG_STATUS) && wbs_sel_i[0];

  assign unused_bits = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i, lane_mask};

  function automatic logic [BITS-1:0] merge_bytes(input logic [BITS-1:0] old_v,
                                                  input logic [BITS-1:0] new_v,
                                                  input logic [BITS-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Read multiplexer; start is write-only so CTRL never reports it.
  always_comb begin
    rd_data = '0;
    rd32    = '0;
    case (reg_idx)
      REG_CTRL: begin
        rd_data[CTRL_ENABLE_BIT] = enable;
        rd_data[CTRL_CONT_BIT]   = continuous;
      end
      REG_WIDTH:  rd_data = width;
      REG_HEIGHT: rd_data = height;
      REG_HBLANK: rd_data = hblank;
      REG_STATUS: begin
        rd_data[STAT_BUSY_BIT]              = busy;
        rd_data[STAT_ERR_BIT]               = err_sticky;
        rd_data[STAT_ABORT_BIT]             = abort_sticky;
        rd_data[STAT_FCNT_LSB +: FCNT_W]    = frame_cnt;
      end
      default: rd_data = '0;
    endcase
    rd32[BITS-1:0] = rd_data;
  end

  // Register bank, ack and read-data capture. A sticky flag set request
  // wins over a simultaneous write-1-to-clear so an event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      enable       <= 1'b0;
      continuous   <= 1'b0;
      start        <= 1'b0;
      width        <= BITS'(1);
      height       <= BITS'(1);
      hblank       <= '0;
      err_sticky   <= 1'b0;
      abort_sticky <= 1'b0;
    end else begin
      wbs_ack_o <= wb_fire;
      if (wb_fire && !wbs_we_i) begin
        wbs_dat_o <= rd32;
      end
      start <= ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_START_BIT];
      if (ctrl_wr && wbs_sel_i[0]) begin
        enable     <= wbs_dat_i[CTRL_ENABLE_BIT];
        continuous <= wbs_dat_i[CTRL_CONT_BIT];
      end
      if (wr_fire && (reg_idx == REG_WIDTH)) begin
        width <= merge_bytes(width, wr_data, byte_mask);
      end
      if (wr_fire && (reg_idx == REG_HEIGHT)) begin
        height <= merge_bytes(height, wr_data, byte_mask);
      end
      if (wr_fire && (reg_idx == REG_HBLANK)) begin
        hblank <= merge_bytes(hblank, wr_data, byte_mask);
      end
      err_sticky   <= set_err   | (err_sticky   & ~(status_wr & wbs_dat_i[STAT_ERR_BIT]));
      abort_sticky <= set_abort | (abort_sticky & ~(status_wr & wbs_dat_i[STAT_ABORT_BIT]));
    end
  end

endmodule

// File: rtl/isp_frame_sequencer.sv
// Frame timing controller for the ISP pixel datapath.
// Walks a WIDTH x HEIGHT raster with optional horizontal blanking, honouring
// downstream backpressure, and reports completion with an interrupt pulse.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   wbs_*                    : Wishbone slave for the register bank
//   pix_ready                : downstream accepts the current pixel
//   pix_valid, pix_x, pix_y  : current pixel strobe and coordinates
//   sof, eol, eof            : frame/line markers qualified by pix_valid
//   busy                     : frame in progress (ACTIVE, HBLANK, DONE)
//   irq_frame                : one-cycle pulse on frame completion
module isp_frame_sequencer
  import isp_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int FCNT_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            pix_ready,
  output logic            pix_valid,
  output logic [BITS-1:0] pix_x,
  output logic [BITS-1:0] pix_y,
  output logic            sof,
  output logic            eol,
  output logic            eof,
  output logic            busy,
  output logic            irq_frame
);

  seq_state_t        state, state_next;
  logic              enable, continuous, start;
  logic [BITS-1:0]   width, height, hblank;
  logic [BITS-1:0]   w_sh, h_sh, hb_sh;
  logic [BITS-1:0]   x, y, blank_cnt;
  logic [FCNT_W-1:0] frame_cnt;
  logic              last_x, last_y;
  logic              load_frame, x_inc, line_next, blank_load, blank_dec;
  logic              set_err, set_abort, frame_done;

  isp_seq_regs #(.BITS(BITS), .FCNT_W(FCNT_W)) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .set_err    (set_err),
    .set_abort  (set_abort),
    .enable     (enable),
    .continuous (continuous),
    .start      (start),
    .width      (width),
    .height     (height),
    .hblank     (hblank)
  );

  assign last_x    = (x == w_sh - BITS'(1));
  assign last_y    = (y == h_sh - BITS'(1));
  assign pix_valid = (state == S_ACTIVE);
  assign busy      = (state != S_IDLE);
  assign irq_frame = frame_done;
  assign pix_x     = x;
  assign pix_y     = y;
  assign sof       = pix_valid && (x == '0) && (y == '0);
  assign eol       = pix_valid && last_x;
  assign eof       = pix_valid && last_x && last_y;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control. Losing enable in any busy state aborts
  // the frame before anything else is considered, so an aborted frame never
  // raises irq_frame or advances frame_cnt.
  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    x_inc      = 1'b0;
    line_next  = 1'b0;
    blank_load = 1'b0;
    blank_dec  = 1'b0;
    set_err    = 1'b0;
    set_abort  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && enable) begin
          if ((width == '0) || (height == '0)) begin
            set_err = 1'b1;
          end else begin
            load_frame = 1'b1;
            state_next = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          set_abort  = 1'b1;
          state_next = S_IDLE;
        end else if (pix_ready) begin
          if (!last_x) begin
            x_inc = 1'b1;
          end else if (last_y) begin
            state_next = S_DONE;
          end else if (hb_sh == '0) begin
            line_next = 1'b1;
          end else begin
            blank_load = 1'b1;
            state_next = S_HBLANK;
          end
        end
      end
      S_HBLANK: begin
        if (!enable) begin
          set_abort  = 1'b1;
          state_next = S_IDLE;
        end else if (blank_cnt == '0) begin
          line_next  = 1'b1;
          state_next = S_ACTIVE;
        end else begin
          blank_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          set_abort  = 1'b1;
          state_next = S_IDLE;
        end else begin
          frame_done = 1'b1;
          if (continuous) begin
            load_frame = 1'b1;
            state_next = S_ACTIVE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counters and geometry shadows. The blank counter is loaded with
  // HBLANK-1 so the FSM spends exactly HBLANK cycles in the blank state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_sh      <= '0;
      h_sh      <= '0;
      hb_sh     <= '0;
      x         <= '0;
      y         <= '0;
      blank_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (load_frame) begin
        w_sh  <= width;
        h_sh  <= height;
        hb_sh <= hblank;
        x     <= '0;
        y     <= '0;
      end
      if (x_inc) begin
        x <= x + BITS'(1);
      end
      if (line_next) begin
        x <= '0;
        y <= y + BITS'(1);
      end
      if (blank_load) begin
        blank_cnt <= hb_sh - BITS'(1);
      end
      if (blank_dec) begin
        blank_cnt <= blank_cnt - BITS'(1);
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Self-checking bench for isp_frame_sequencer: table-driven pixel sequences
// plus hand-written sequences for configuration errors, continuous mode,
// mid-frame abort and asynchronous reset.
module tb_isp_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_x, pix_y;
  logic        sof, eol, eof, busy, irq_frame;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        busy;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  isp_frame_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .irq_frame (irq_frame)
  );

  // Hard stop in case a wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic we, input logic [2:0] idx, input logic [31:0] data,
                          output logic [31:0] rdata);
    int   waited = 0;
    logic got_ack = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = 4'hF;
    wbs_adr_i = {27'd0, idx, 2'b00};
    wbs_dat_i = data;
    while (!got_ack && waited < 8) begin
      tick();
      waited++;
      got_ack = wbs_ack_o;
    end
    rdata     = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    if (!got_ack) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL wb_ack_timeout: got no ack, want ack within 8 cycles (idx %0d)", idx);
    end
  endtask

  task automatic wb_write(input logic [2:0] idx, input logic [31:0] data);
    logic [31:0] unused_rd;
    wb_cycle(1'b1, idx, data, unused_rd);
  endtask

  task automatic wb_read_check(input string name, input logic [2:0] idx, input logic [31:0] expected);
    logic [31:0] rd;
    wb_cycle(1'b0, idx, 32'd0, rd);
    check(name, rd, expected);
  endtask

  function automatic vec_t mk_vec(input logic ready, input logic valid, input int x, input int y,
                                  input logic s, input logic l, input logic f,
                                  input logic b, input logic irq);
    vec_t v;
    v.ready = ready;
    v.valid = valid;
    v.x     = 16'(x);
    v.y     = 16'(y);
    v.sof   = s;
    v.eol   = l;
    v.eof   = f;
    v.busy  = b;
    v.irq   = irq;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    pix_ready = v.ready;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check({tag, "_flags"}, {26'd0, pix_valid, sof, eol, eof, busy, irq_frame},
          {26'd0, v.valid, v.sof, v.eol, v.eof, v.busy, v.irq});
    if (v.valid) begin
      check({tag, "_xy"}, {pix_x, pix_y}, {v.x, v.y});
    end
  endtask

  task automatic run_segment(input string tag, input int first, input int last);
    for (int i = first; i < last; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("%s_v%0d", tag, i - first));
      tick();
    end
    pix_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {25'd0, pix_valid, busy, sof, eol, eof, irq_frame, wbs_ack_o}, 32'd0);
    check({tag, "_xy"}, {pix_x, pix_y}, 32'd0);
    check({tag, "_dat"}, wbs_dat_o, 32'd0);
  endtask

  initial begin
    int s1, s2, s3, s_end;

    reset_n   = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
    wbs_adr_i = 32'd0;
    wbs_dat_i = 32'd0;
    pix_ready = 1'b1;

    // Frame 4x2, no blanking.
    s1 = vecs.size();
    vecs.push_back(mk_vec(1, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 2, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 3, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 2, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 3, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Frame 3x2 with two blank cycles between rows.
    s2 = vecs.size();
    vecs.push_back(mk_vec(1, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 2, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk_vec(1, 1, 2, 1, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Frame 2x1 stalled for three cycles on its last pixel.
    s3 = vecs.size();
    vecs.push_back(mk_vec(1, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk_vec(0, 1, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(0, 1, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(0, 1, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(1, 1, 1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0));
    s_end = vecs.size();

    #1;
    check_reset_outputs("reset_initial");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tick();
    wb_read_check("reset_width", 3'd1, 32'd1);
    wb_read_check("reset_height", 3'd2, 32'd1);
    wb_read_check("reset_ctrl", 3'd0, 32'd0);
    wb_read_check("reset_status", 3'd4, 32'd0);
    wb_read_check("unmapped_idx5", 3'd5, 32'd0);

    $display("[TB] frame 4x2, hblank 0");
    wb_write(3'd1, 32'd4);
    wb_write(3'd2, 32'd2);
    wb_write(3'd3, 32'd0);
    wb_write(3'd0, 32'd1);
    wb_write(3'd0, 32'd5);
    tick();
    check("ack_single_cycle", {31'd0, wbs_ack_o}, 32'd0);
    run_segment("f4x2", s1, s2);
    wb_read_check("ctrl_start_selfclear", 3'd0, 32'd1);
    wb_read_check("status_after_f1", 3'd4, 32'h0100);

    $display("[TB] frame 3x2, hblank 2");
    wb_write(3'd1, 32'd3);
    wb_write(3'd3, 32'd2);
    wb_write(3'd0, 32'd5);
    tick();
    run_segment("f3x2hb", s2, s3);
    wb_read_check("status_after_f2", 3'd4, 32'h0200);

    $display("[TB] frame 2x1 with backpressure");
    wb_write(3'd1, 32'd2);
    wb_write(3'd2, 32'd1);
    wb_write(3'd0, 32'd5);
    tick();
    run_segment("f2x1stall", s3, s_end);
    wb_read_check("status_after_f3", 3'd4, 32'h0300);

    $display("[TB] zero width start");
    wb_write(3'd1, 32'd0);
    wb_write(3'd0, 32'd5);
    tick();
    checkOutput(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0), "zw_idle0");
    tick();
    checkOutput(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0), "zw_idle1");
    wb_read_check("status_err_set", 3'd4, 32'h0302);
    wb_write(3'd4, 32'h2);
    wb_read_check("status_err_clear", 3'd4, 32'h0300);

    $display("[TB] continuous mode, shadowing and abort");
    wb_write(3'd1, 32'd2);
    wb_write(3'd2, 32'd2);
    wb_write(3'd3, 32'd0);
    wb_write(3'd0, 32'd7);
    tick();
    checkOutput(mk_vec(1, 1, 0, 0, 1, 0, 0, 1, 0), "cont_f1_00");
    wb_write(3'd1, 32'd3);
    checkOutput(mk_vec(1, 1, 1, 0, 0, 1, 0, 1, 0), "cont_f1_10");
    tick();
    checkOutput(mk_vec(1, 1, 0, 1, 0, 0, 0, 1, 0), "cont_f1_01");
    tick();
    checkOutput(mk_vec(1, 1, 1, 1, 0, 1, 1, 1, 0), "cont_f1_11");
    tick();
    checkOutput(mk_vec(1, 0, 0, 0, 0, 0, 0, 1, 1), "cont_f1_done");
    tick();
    checkOutput(mk_vec(1, 1, 0, 0, 1, 0, 0, 1, 0), "cont_f2_00");
    tick();
    checkOutput(mk_vec(1, 1, 1, 0, 0, 0, 0, 1, 0), "cont_f2_10");
    tick();
    checkOutput(mk_vec(1, 1, 2, 0, 0, 1, 0, 1, 0), "cont_f2_20");
    wb_write(3'd0, 32'd2);
    tick();
    checkOutput(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_idle");
    wb_read_check("status_abort", 3'd4, 32'h0404);

    $display("[TB] asynchronous reset mid-frame");
    wb_write(3'd0, 32'd1);
    wb_write(3'd1, 32'd4);
    wb_write(3'd2, 32'd4);
    wb_write(3'd0, 32'd5);
    tick();
    tick();
    checkOutput(mk_vec(1, 1, 1, 0, 0, 0, 0, 1, 0), "pre_reset");
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    checkOutput(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_idle");
    wb_read_check("post_reset_width", 3'd1, 32'd1);
    wb_read_check("post_reset_status", 3'd4, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
